// File: rtl/branch_predictor.sv
// Branch prediction unit for the IF stage: a tagged BTB with 2-bit saturating
// counters, trained from EX-stage resolutions, plus saturating accuracy counters.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int STAT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        strategy,
  input  logic [ADDR_W-1:0] if_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_mispredict,
  output logic [STAT_W-1:0] stat_updates,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  typedef enum logic [1:0] {
    STRAT_NOT_TAKEN = 2'b00,
    STRAT_TAKEN     = 2'b01,
    STRAT_DELAY     = 2'b10,
    STRAT_DYNAMIC   = 2'b11
  } strategy_t;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;
  logic             unused_pc_lsbs;

  assign lk_idx = if_pc[IDX_W+1:2];
  assign lk_tag = if_pc[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Instructions are word aligned, so the byte offset never selects anything.
  assign unused_pc_lsbs = ^{if_pc[1:0], upd_pc[1:0]};

  // Lookup reads registered state only, so a same-cycle update is not seen.
  always_comb begin
    pred_taken = 1'b0;
    case (strategy_t'(strategy))
      STRAT_TAKEN:   pred_taken = lk_hit;
      STRAT_DYNAMIC: pred_taken = lk_hit & ctr_q[lk_idx][1];
      default:       pred_taken = 1'b0;
    endcase
    if (rst) pred_taken = 1'b0;
    pred_target = pred_taken ? target_q[lk_idx] : if_pc + ADDR_W'(4);
  end

  // NOTE: sequential state uses non-blocking assignments so every entry and
  // counter samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table is reset entry by entry because valid bits must clear;
      // this keeps it in flops rather than a RAM macro, which is fine at this size.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        ctr_q[i]    <= 2'b01;
        target_q[i] <= '0;
      end
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else if (upd_valid) begin
      if (up_hit) begin
        if (upd_taken) begin
          if (ctr_q[up_idx] != 2'b11) ctr_q[up_idx] <= ctr_q[up_idx] + 2'd1;
          target_q[up_idx] <= upd_target;
        end else if (ctr_q[up_idx] != 2'b00) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocation replaces whatever aliased there, starting weakly taken.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        ctr_q[up_idx]    <= 2'b10;
        target_q[up_idx] <= upd_target;
      end

      if (stat_updates != '1) stat_updates <= stat_updates + STAT_W'(1);
      if (upd_mispredict && (stat_mispredicts != '1))
        stat_mispredicts <= stat_mispredicts + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: counter training, saturation, aliasing,
// strategy sweep, same-cycle lookup/update, statistics and reset.
module tb_branch_predictor;

  localparam int STAT_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  strategy;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [STAT_W-1:0] stat_updates;
  logic [STAT_W-1:0] stat_mispredicts;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.ENTRIES(16), .ADDR_W(32), .STAT_W(STAT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .strategy         (strategy),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pred(input string tag, input logic [31:0] pc, input logic exp_t,
                      input logic [31:0] exp_tgt);
    if_pc = pc;
    #1;
    check({tag, "_taken"}, {31'd0, pred_taken}, {31'd0, exp_t});
    check({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic stats(input string tag, input int exp_u, input int exp_m);
    check({tag, "_upd"}, 32'(stat_updates), exp_u);
    check({tag, "_mis"}, 32'(stat_mispredicts), exp_m);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic mis);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = taken; upd_target = tgt; upd_mispredict = mis;
    step();
    upd_valid = 1'b0; upd_taken = 1'b0; upd_mispredict = 1'b0;
  endtask

  initial begin
    rst = 1'b1; strategy = 2'b11; if_pc = 32'h10;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0; upd_mispredict = 1'b0;
    step(); step();
    pred("rst_hold", 32'h10, 1'b0, 32'h14);
    stats("rst_hold", 0, 0);
    rst = 1'b0;
    step();
    pred("rst_done", 32'h10, 1'b0, 32'h14);
    stats("rst_done", 0, 0);

    // Counter training at 0x3C (index 15, tag 0)
    upd(32'h3C, 1'b1, 32'h48, 1'b0);
    pred("alloc_ctr10", 32'h3C, 1'b1, 32'h48);
    upd(32'h3C, 1'b0, 32'h0, 1'b0);
    pred("ctr01", 32'h3C, 1'b0, 32'h40);
    upd(32'h3C, 1'b1, 32'h48, 1'b0);
    upd(32'h3C, 1'b1, 32'h48, 1'b0);
    upd(32'h3C, 1'b0, 32'h0, 1'b0);
    pred("ctr11_to_10", 32'h3C, 1'b1, 32'h48);

    // Saturation: ctr 10 -> 11, then down to 00 and beyond
    upd(32'h3C, 1'b1, 32'h48, 1'b0);
    pred("ctr11", 32'h3C, 1'b1, 32'h48);
    for (int i = 0; i < 4; i++) upd(32'h3C, 1'b0, 32'h0, 1'b0);
    pred("ctr00", 32'h3C, 1'b0, 32'h40);
    upd(32'h3C, 1'b0, 32'h0, 1'b0);
    pred("ctr00_sat", 32'h3C, 1'b0, 32'h40);
    upd(32'h3C, 1'b1, 32'h48, 1'b0);
    pred("ctr00_to_01", 32'h3C, 1'b0, 32'h40);

    // Strategy sweep with entry valid, ctr 01, target 0x48
    strategy = 2'b00; pred("strat00", 32'h3C, 1'b0, 32'h40);
    strategy = 2'b01; pred("strat01", 32'h3C, 1'b1, 32'h48);
    strategy = 2'b10; pred("strat10", 32'h3C, 1'b0, 32'h40);
    strategy = 2'b11; pred("strat11", 32'h3C, 1'b0, 32'h40);

    // Aliasing: 0x7C shares index 15 with tag 1
    strategy = 2'b01;
    pred("alias_miss", 32'h7C, 1'b0, 32'h80);
    upd(32'h7C, 1'b1, 32'h18, 1'b0);
    pred("alias_hit", 32'h7C, 1'b1, 32'h18);
    pred("alias_evicted", 32'h3C, 1'b0, 32'h40);
    strategy = 2'b11;
    pred("alias_dyn", 32'h7C, 1'b1, 32'h18);

    // Same-cycle lookup and update on an empty entry
    rst = 1'b1; step(); rst = 1'b0;
    if_pc = 32'h3C;
    upd_valid = 1'b1; upd_pc = 32'h3C; upd_taken = 1'b1; upd_target = 32'h48;
    upd_mispredict = 1'b0;
    pred("same_cycle_old", 32'h3C, 1'b0, 32'h40);
    step();
    upd_valid = 1'b0; upd_taken = 1'b0;
    pred("same_cycle_new", 32'h3C, 1'b1, 32'h48);

    // Statistics: 5 updates, 2 mispredicts (one already counted above)
    upd(32'h100, 1'b0, 32'h0, 1'b1);
    upd(32'h104, 1'b0, 32'h0, 1'b0);
    upd(32'h108, 1'b1, 32'h200, 1'b1);
    upd(32'h3C, 1'b0, 32'h0, 1'b0);
    stats("five_two", 5, 2);
    upd_mispredict = 1'b1; upd_taken = 1'b1;
    step();
    upd_mispredict = 1'b0; upd_taken = 1'b0;
    stats("idle_ignored", 5, 2);
    for (int i = 0; i < 5; i++) upd(32'h200, 1'b0, 32'h0, 1'b1);
    stats("upd_sat", 7, 7);
    upd(32'h200, 1'b0, 32'h0, 1'b1);
    stats("both_sat", 7, 7);

    // Mid-operation reset together with an update: reset wins
    rst = 1'b1;
    upd(32'h3C, 1'b1, 32'h60, 1'b1);
    rst = 1'b0;
    pred("rst_upd_3c", 32'h3C, 1'b0, 32'h40);
    pred("rst_upd_108", 32'h108, 1'b0, 32'h10C);
    stats("rst_upd", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
